spm_seq_ctrl: RTL and testbench

Sequencer that drives one serial-parallel multiplier (spm) core built from a chain of carry-save adder cells.
- Accepts a multiplicand/multiplier pair over a valid/ready handshake.
- Clears the core, presents the multiplicand in parallel on core_x and feeds the multiplier LSB-first on core_y.
- Collects the serial product bits from core_p into a 2*WIDTH result, which it returns over a second valid/ready handshake.
- Sits between the accelerator's request interface and the spm datapath; owns all core timing.

---
 rtl/spm_seq_ctrl.sv | 99 +++++++++
 tb/tb_spm_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spm_seq_ctrl.sv
// Sequencer for a serial-parallel multiplier core: captures an operand pair,
// clears the core, streams the multiplier LSB-first and gathers the serial product.
module spm_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1,
    parameter int LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 core_clr,
    output logic [WIDTH-1:0]     core_x,
    output logic                 core_y,
    input  logic                 core_p,
    output logic                 busy
);
    localparam int N  = 2 * WIDTH + LAT;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW-1:0] TWO_W  = CW'(2 * WIDTH);
    localparam logic [CW-1:0] LAT_C  = CW'(LAT);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 fill;

    // Once the multiplier bits are used up, the shift register is refilled with
    // its own sign bit (or zero), which supplies the upper-half extension.
    assign fill = (SIGNED != 0) ? b_q[WIDTH-1] : 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_a;
                    b_d     = in_b;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                b_d   = {fill, b_q[WIDTH-1:1]};
                if (cnt_q >= LAT_C)
                    p_d = {core_p, p_q[2*WIDTH-1:1]};
                if (cnt_q == LAST)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_p     = p_q;
    assign core_clr  = (state_q == CLR);
    assign core_x    = x_q;
    assign core_y    = (state_q == SHIFT && cnt_q < TWO_W) ? b_q[0] : 1'b0;
    assign busy      = (state_q == CLR) || (state_q == SHIFT);
endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Drives an unsigned and a signed controller in lockstep, each wired to a
// behavioural serial multiplier core, and checks products against a*b.
module tb_spm_seq_ctrl;
    localparam int W   = 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;

    logic           in_ready[2], out_valid[2], core_clr[2], core_y[2], core_p[2], busy[2];
    logic [2*W-1:0] out_p[2];
    logic [W-1:0]   core_x[2];

    int errors = 0;
    int checks = 0;
    int clr_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    spm_seq_ctrl #(.WIDTH(W), .SIGNED(0), .LAT(LAT)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_p(out_p[0]), .core_clr(core_clr[0]), .core_x(core_x[0]),
        .core_y(core_y[0]), .core_p(core_p[0]), .busy(busy[0]));

    spm_seq_ctrl #(.WIDTH(W), .SIGNED(1), .LAT(LAT)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_p(out_p[1]), .core_clr(core_clr[1]), .core_x(core_x[1]),
        .core_y(core_y[1]), .core_p(core_p[1]), .busy(busy[1]));

    // Core model: product bit t depends only on x and the first t+1 multiplier
    // bits, so it is bit t of x * (multiplier bits received so far).
    longint      yacc[2];
    int          tcnt[2];
    logic [LAT-1:0] dly[2];

    function automatic logic pbit(input longint x, input longint y, input int t);
        longint pr;
        pr = x * y;
        return pr[t];
    endfunction

    function automatic longint ext(input logic [W-1:0] v, input bit sgn);
        longint r;
        if (sgn) r = longint'($signed(v));
        else     r = longint'({56'd0, v});
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_core
        assign core_p[g] = dly[g][LAT-1];
        always @(posedge clk) begin
            clr_cnt[g] <= clr_cnt[g] + (core_clr[g] ? 1 : 0);
            if (core_clr[g]) begin
                yacc[g] <= 0;
                tcnt[g] <= 0;
                dly[g]  <= '0;
            end else if (tcnt[g] < 40) begin
                yacc[g] <= yacc[g] | (longint'(core_y[g]) << tcnt[g]);
                tcnt[g] <= tcnt[g] + 1;
                dly[g]  <= LAT'((dly[g] << 1) | LAT'(pbit(ext(core_x[g], g == 1),
                            yacc[g] | (longint'(core_y[g]) << tcnt[g]), tcnt[g])));
            end else begin
                dly[g]  <= LAT'(dly[g] << 1);
            end
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_in_ready"},  longint'(in_ready[i]),  1);
            chk({tag, "_out_valid"}, longint'(out_valid[i]), 0);
            chk({tag, "_out_p"},     longint'(out_p[i]),     0);
            chk({tag, "_core_clr"},  longint'(core_clr[i]),  0);
            chk({tag, "_core_x"},    longint'(core_x[i]),    0);
            chk({tag, "_core_y"},    longint'(core_y[i]),    0);
            chk({tag, "_busy"},      longint'(busy[i]),      0);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input int hold);
        longint exp[2];
        int n;
        int c0[2];
        for (int i = 0; i < 2; i++)
            exp[i] = (ext(a, i == 1) * ext(b, i == 1)) & 64'hFFFF;
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", longint'(in_ready[0]), 1);
        c0 = clr_cnt;
        @(posedge clk); #1;
        n = 0;
        while (n < 100) begin
            if (noise) begin
                in_a = W'($urandom); in_b = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1; n++;
            if (out_valid[0]) break;
        end
        in_valid = 1'b0;
        // DONE begins 2W+LAT+1 edges after the accepting edge.
        chk("latency", n, 2 * W + LAT + 1);
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "prod_u" : "prod_s", longint'(out_p[i]), exp[i]);
            chk("out_valid_sync", longint'(out_valid[i]), 1);
            chk("clr_pulses", clr_cnt[i] - c0[i], 1);
            chk("busy_done", longint'(busy[i]), 0);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("hold_valid", longint'(out_valid[i]), 1);
                chk("hold_p", longint'(out_p[i]), exp[i]);
                chk("hold_in_ready", longint'(in_ready[i]), 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drop_valid", longint'(out_valid[i]), 0);
            chk("ready_back", longint'(in_ready[i]), 1);
        end
    endtask

    initial begin
        #12;
        chk_reset_state("reset");
        @(negedge clk); rst = 1'b0;
        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_outready", longint'(out_valid[0]), 0);

        run_op(8'd3, 8'd5, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b0, 0);
        run_op(8'hFD, 8'h05, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'h7F, 8'h80, 1'b0, 20);
        run_op(8'h5A, 8'hC3, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 0);
        for (int r = 0; r < 20; r++)
            run_op(W'($urandom), W'($urandom), r[0], int'($urandom_range(0, 3)));

        // Abort at SHIFT cnt=5: accept edge, CLR edge, then five more edges.
        in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_state("async_rst");
        @(negedge clk); rst = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            chk("no_out_after_abort", longint'(out_valid[0] | out_valid[1]), 0);
        end
        run_op(8'd7, 8'd6, 1'b0, 0);
        run_op(8'hF9, 8'd6, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
